// File: rtl/serial_add_pkg.sv
// ============================================================================
// serial_add_pkg : shared types and defaults for the bit-serial adder.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

   localparam int SERIAL_ADD_W_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_add_ctrl_fa_cell.sv
// ============================================================================
// fa_cell : combinational 1-bit full adder from two half-adder stages.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fa_cell (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   logic w_p;
   logic w_g;
   logic w_t;

   assign w_p = a_i ^ b_i;
   assign w_g = a_i & b_i;
   assign s_o = w_p ^ c_i;
   assign w_t = w_p & c_i;
   assign c_o = w_g | w_t;

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// serial_add_ctrl : bit-serial WIDTH-bit adder behind valid/ready handshakes.
// Optional signed-overflow output enabled by macro SERIAL_ADD_OVF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = SERIAL_ADD_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef SERIAL_ADD_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int                 C_CNT_W = $clog2(WIDTH + 1);
   localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);
   localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

   state_t             state_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sum_q;
   logic [WIDTH-1:0]   w_sum_d;
   logic               carry_q;
   logic               cout_q;
   logic [C_CNT_W-1:0] cnt_q;
   logic               w_s;
   logic               w_c;
`ifdef SERIAL_ADD_OVF_EN
   logic               ovf_q;
`endif

   fa_cell u_fa (
      .a_i (a_q[0]),
      .b_i (b_q[0]),
      .c_i (carry_q),
      .s_o (w_s),
      .c_o (w_c)
   );

   // New sum bits enter at the MSB so the LSB-first stream lands in place.
   generate
      if (WIDTH == 1) begin : g_w1
         assign w_sum_d = w_s;
      end else begin : g_wn
         assign w_sum_d = {w_s, sum_q[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               sum_q   <= w_sum_d;
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= w_c;
               cnt_q   <= cnt_q + C_ONE;
               if (cnt_q == C_LAST) begin
                  state_q <= S_DONE;
                  cout_q  <= w_c;
`ifdef SERIAL_ADD_OVF_EN
                  // carry_q here is the carry into the MSB position.
                  ovf_q   <= carry_q ^ w_c;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_BUSY);
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller that time-shares one 1-bit full-adder cell over WIDTH-bit operands.
- Accepts an operand pair over a valid/ready handshake and feeds one bit pair per cycle, LSB first, through the cell while holding the carry in a register.
- Returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits between an operand source and a result consumer wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1 to 64).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand pair and cin are valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for the addition.
- out_valid  out  1  sum and cout are valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry-out of bit WIDTH-1.
- busy  out  1  high in S_BUSY.

Behaviour:
- States and transitions:
  - S_IDLE -> S_BUSY on in_valid && in_ready.
  - S_BUSY -> S_DONE after WIDTH bit-cycles.
  - S_DONE -> S_IDLE on out_valid && out_ready.
- Reset (rst_n=0 at a rising edge):
  - state=S_IDLE; shift registers, carry register, bit counter, sum and cout cleared to 0.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- in_ready = (state==S_IDLE). out_valid = (state==S_DONE). Both decode from state only, with no combinational path from in_valid or out_ready.
- Accept edge:
  - a and b load into shift registers; carry register loads cin; counter loads 0.
  - a, b and cin are ignored at all other times.
- Each S_BUSY cycle:
  - The cell computes s = a[0]^b[0]^c and c' = majority(a[0],b[0],c).
  - s shifts into the MSB of the sum register; the operand registers shift right; carry register takes c'; counter increments.
  - At counter==WIDTH-1 the transition to S_DONE occurs on the same edge, and cout takes the final c'.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge. Minimum issue interval is WIDTH+2 cycles (one IDLE, WIDTH BUSY, one DONE with out_ready=1).
- Back-pressure: in S_DONE, sum and cout stay stable until the handshake completes. After the handshake, sum and cout keep their last value; they are not cleared.
- WIDTH=1: a single S_BUSY cycle, then S_DONE.
- Counter width is $clog2(WIDTH+1).
- Reset mid-operation (S_BUSY or S_DONE): the operation is aborted and discarded, with no out_valid pulse; next cycle in_ready=1.
- in_valid asserted while in_ready=0: no effect; the source must hold the request until in_ready.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), the signed two's-complement overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf is captured in the final S_BUSY cycle, held and stable with sum, and reset to 0.
- Undefined: port ovf and its register are absent; all other behaviour is identical.

Decomposition:
- Package serial_add_pkg holds:
  - typedef enum logic [1:0] state_t {S_IDLE, S_BUSY, S_DONE}.
  - localparam default width SERIAL_ADD_W_DEF=8.
- Sub-module fa_cell (combinational 1-bit full adder built from two XOR/AND half-adder stages plus an OR for carry), instantiated once.
- FSM, counter, and shift and carry registers stay in serial_add_ctrl.

Test Plan:
- Reset: rst_n=0 for 3 cycles during random traffic -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0 on the first cycle after release.
- Basic add, WIDTH=8: a=8'h0F, b=8'h01, cin=0, out_ready=1 -> out_valid exactly 8 cycles after accept; sum=8'h10, cout=0; busy high for exactly 8 cycles.
- Carries:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1 (ovf=0).
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
  - With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1.
- Back-pressure: out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new data -> sum and cout held, in_ready=0, new pair not accepted; after out_ready=1, the new pair is accepted in the next IDLE cycle.
- Abort: rst_n=0 on the 3rd S_BUSY cycle of a=8'h55, b=8'hAA -> IDLE next cycle, out_valid never asserted; the following add 8'h01+8'h01 returns sum=8'h02.
- Back-to-back: 4 operations with in_valid and out_ready held high -> accepts spaced exactly WIDTH+2 cycles apart and results in order.
